// File: rtl/uart_cmd_parser.sv
// Frames the UART byte stream (SYNC CMD ADDR DHI DLO CSUM) into validated register-write commands.
// Latency: cmd_valid/csum_err/tmo_err and the cmd/addr/wdata update appear one cycle after the CSUM strobe.
// Backpressure: none; the receiver cannot be stalled, so every rx_new byte is consumed in the cycle it arrives.
// Build option: define UART_CMD_PARSER_ERR_CNT_EN to get the saturating err_count; otherwise err_count reads 0.
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 26040,
    parameter int         CTR_SIZE     = $clog2(TIMEOUT_CLKS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_new,
    output logic        cmd_valid,
    output logic [7:0]  cmd,
    output logic [7:0]  addr,
    output logic [15:0] wdata,
    output logic        busy,
    output logic        csum_err,
    output logic        tmo_err,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        HUNT     = 3'd0,
        GET_CMD  = 3'd1,
        GET_ADDR = 3'd2,
        GET_DHI  = 3'd3,
        GET_DLO  = 3'd4,
        GET_CSUM = 3'd5
    } state_t;

    // The timeout fires on the cycle the counter would step onto TIMEOUT_CLKS-1,
    // i.e. TIMEOUT_CLKS-1 edges after the last accepted byte.
    localparam logic [CTR_SIZE-1:0] TMO_LAST = CTR_SIZE'(TIMEOUT_CLKS - 2);

    state_t              state_q, state_d;
    logic [CTR_SIZE-1:0] cnt_q, cnt_d;
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          sh_cmd_q, sh_cmd_d;
    logic [7:0]          sh_addr_q, sh_addr_d;
    logic [7:0]          sh_dhi_q, sh_dhi_d;
    logic [7:0]          sh_dlo_q, sh_dlo_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [7:0]          addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                csum_err_q, csum_err_d;
    logic                tmo_err_q, tmo_err_d;
    logic                busy_q;

    // Next-state, checksum, shadow capture and pulse generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        csum_d      = csum_q;
        sh_cmd_d    = sh_cmd_q;
        sh_addr_d   = sh_addr_q;
        sh_dhi_d    = sh_dhi_q;
        sh_dlo_d    = sh_dlo_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cmd_valid_d = 1'b0;
        csum_err_d  = 1'b0;
        tmo_err_d   = 1'b0;

        case (state_q)
            HUNT: begin
                cnt_d = '0;
                if (rx_new && (rx_data == SYNC_BYTE)) begin
                    state_d = GET_CMD;
                    csum_d  = 8'h00;
                end
            end
            GET_CMD: begin
                if (rx_new) begin
                    sh_cmd_d = rx_data;
                    csum_d   = csum_q ^ rx_data;
                    cnt_d    = '0;
                    state_d  = GET_ADDR;
                end
            end
            GET_ADDR: begin
                if (rx_new) begin
                    sh_addr_d = rx_data;
                    csum_d    = csum_q ^ rx_data;
                    cnt_d     = '0;
                    state_d   = GET_DHI;
                end
            end
            GET_DHI: begin
                if (rx_new) begin
                    sh_dhi_d = rx_data;
                    csum_d   = csum_q ^ rx_data;
                    cnt_d    = '0;
                    state_d  = GET_DLO;
                end
            end
            GET_DLO: begin
                if (rx_new) begin
                    sh_dlo_d = rx_data;
                    csum_d   = csum_q ^ rx_data;
                    cnt_d    = '0;
                    state_d  = GET_CSUM;
                end
            end
            GET_CSUM: begin
                if (rx_new) begin
                    if (rx_data == csum_q) begin
                        cmd_d       = sh_cmd_q;
                        addr_d      = sh_addr_q;
                        wdata_d     = {sh_dhi_q, sh_dlo_q};
                        cmd_valid_d = 1'b1;
                    end else begin
                        csum_err_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = HUNT;
                end
            end
            default: begin
                state_d = HUNT;
                cnt_d   = '0;
            end
        endcase

        // Inter-byte timeout inside a frame; a byte in the expiry cycle takes precedence.
        if ((state_q != HUNT) && !rx_new) begin
            if (cnt_q == TMO_LAST) begin
                tmo_err_d = 1'b1;
                state_d   = HUNT;
                cnt_d     = '0;
                sh_cmd_d  = 8'h00;
                sh_addr_d = 8'h00;
                sh_dhi_d  = 8'h00;
                sh_dlo_d  = 8'h00;
            end else begin
                cnt_d = cnt_q + CTR_SIZE'(1);
            end
        end
    end

    // State, datapath and registered outputs; reset drops any partial frame silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            cnt_q       <= '0;
            csum_q      <= 8'h00;
            sh_cmd_q    <= 8'h00;
            sh_addr_q   <= 8'h00;
            sh_dhi_q    <= 8'h00;
            sh_dlo_q    <= 8'h00;
            cmd_q       <= 8'h00;
            addr_q      <= 8'h00;
            wdata_q     <= 16'h0000;
            cmd_valid_q <= 1'b0;
            csum_err_q  <= 1'b0;
            tmo_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            sh_cmd_q    <= sh_cmd_d;
            sh_addr_q   <= sh_addr_d;
            sh_dhi_q    <= sh_dhi_d;
            sh_dlo_q    <= sh_dlo_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cmd_valid_q <= cmd_valid_d;
            csum_err_q  <= csum_err_d;
            tmo_err_q   <= tmo_err_d;
            busy_q      <= (state_d != HUNT);
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign busy      = busy_q;
    assign csum_err  = csum_err_q;
    assign tmo_err   = tmo_err_q;

`ifdef UART_CMD_PARSER_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of dropped frames, updated alongside the error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else if ((csum_err_d || tmo_err_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_new;
    logic        cmd_valid;
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        busy;
    logic        csum_err;
    logic        tmo_err;
    logic [7:0]  err_count;

    uart_cmd_parser #(
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_new    (rx_new),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .csum_err  (csum_err),
        .tmo_err   (tmo_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // expected pulse vector is {cmd_valid, csum_err, tmo_err}
    typedef struct {
        logic [2:0]  pv;
        logic [7:0]  c;
        logic [7:0]  a;
        logic [15:0] w;
        logic [7:0]  ec;
    } exp_t;

    typedef struct {
        int          n;
        logic [7:0]  b [8];
        logic [2:0]  pv;
        logic [7:0]  c;
        logic [7:0]  a;
        logic [15:0] w;
    } vec_t;

    exp_t        sb [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [7:0]  m_cmd   = 8'h00;
    logic [7:0]  m_addr  = 8'h00;
    logic [15:0] m_wdata = 16'h0000;
    logic [7:0]  m_errc  = 8'h00;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
        end
    endtask

    task automatic push_cmd(input logic [7:0] c, input logic [7:0] a, input logic [15:0] w);
        exp_t e;
        m_cmd   = c;
        m_addr  = a;
        m_wdata = w;
        e = '{pv: 3'b100, c: c, a: a, w: w, ec: m_errc};
        sb.push_back(e);
    endtask

    task automatic push_err(input logic [2:0] pv);
        exp_t e;
`ifdef UART_CMD_PARSER_ERR_CNT_EN
        if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
`endif
        e = '{pv: pv, c: m_cmd, a: m_addr, w: m_wdata, ec: m_errc};
        sb.push_back(e);
    endtask

    // With gap=1 each strobe is followed by an idle cycle; gap=0 streams bytes on consecutive cycles.
    // Returns at the falling edge just after the last byte's sampling edge.
    task automatic send_bytes(input logic [7:0] bq [$], input bit gap);
        foreach (bq[j]) begin
            @(negedge clk);
            rx_data = bq[j];
            rx_new  = 1'b1;
            if (gap) begin
                @(negedge clk);
                rx_new = 1'b0;
            end
        end
        if (!gap) begin
            @(negedge clk);
            rx_new = 1'b0;
        end
    endtask

    // Scoreboard monitor: every output pulse must match the next queued expectation.
    logic [2:0] pulses;
    logic       prev_pulse = 1'b0;
    exp_t       got_e;
    always @(negedge clk) begin
        pulses = {cmd_valid, csum_err, tmo_err};
        if (pulses != 3'b000) begin
            check("pulse_onehot", $countones(pulses), 1);
            check("pulse_spacing", prev_pulse, 0);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse actual=%b expected=none", pulses);
            end else begin
                got_e = sb.pop_front();
                check("pulse_kind", pulses, got_e.pv);
                check("out_cmd", cmd, got_e.c);
                check("out_addr", addr, got_e.a);
                check("out_wdata", wdata, got_e.w);
                check("err_count", err_count, got_e.ec);
            end
        end
        prev_pulse = (pulses != 3'b000);
    end

    vec_t tbl [6];

    initial begin
        logic [7:0] bq [$];
        int got;

        tbl[0] = '{n: 6, b: '{8'hA5, 8'h01, 8'h10, 8'h12, 8'h34, 8'h37, 8'h00, 8'h00}, pv: 3'b100, c: 8'h01, a: 8'h10, w: 16'h1234};
        tbl[1] = '{n: 6, b: '{8'hA5, 8'h01, 8'h10, 8'h12, 8'h34, 8'h38, 8'h00, 8'h00}, pv: 3'b010, c: 8'h00, a: 8'h00, w: 16'h0000};
        tbl[2] = '{n: 8, b: '{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00}, pv: 3'b100, c: 8'hA5, a: 8'hA5, w: 16'h0000};
        tbl[3] = '{n: 6, b: '{8'hA5, 8'h02, 8'h20, 8'hAB, 8'hCD, 8'h44, 8'h00, 8'h00}, pv: 3'b100, c: 8'h02, a: 8'h20, w: 16'hABCD};
        tbl[4] = '{n: 6, b: '{8'hA5, 8'h7F, 8'h00, 8'hFF, 8'h00, 8'h80, 8'h00, 8'h00}, pv: 3'b100, c: 8'h7F, a: 8'h00, w: 16'hFF00};
        tbl[5] = '{n: 6, b: '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00}, pv: 3'b010, c: 8'h00, a: 8'h00, w: 16'h0000};

        rst_n   = 1'b0;
        rx_new  = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd", cmd, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_csum_err", csum_err, 0);
        check("rst_tmo_err", tmo_err, 0);
        check("rst_err_count", err_count, 0);
        rst_n = 1'b1;

        // Table-driven frames: pulse must appear exactly one cycle after the CSUM strobe.
        for (int i = 0; i < 6; i++) begin
            bq.delete();
            for (int j = 0; j < tbl[i].n; j++) bq.push_back(tbl[i].b[j]);
            if (tbl[i].pv == 3'b100) push_cmd(tbl[i].c, tbl[i].a, tbl[i].w);
            else                     push_err(tbl[i].pv);
            send_bytes(bq, 1'b1);
            #1;
            check("frame_latency", sb.size(), 0);
            check("frame_busy_end", busy, 0);
            @(negedge clk);
        end

        // Timeout: SYNC + CMD then silence.
        push_err(3'b001);
        send_bytes('{8'hA5, 8'h01}, 1'b1);
        check("tmo_busy_mid", busy, 1);
        got = -1;
        for (int k = 1; k <= TMO + 5; k++) begin
            @(posedge clk);
            #1;
            if (tmo_err && got < 0) got = k;
        end
        check("tmo_latency", got, TMO - 1);
        check("tmo_busy_after", busy, 0);
        check("tmo_sb_drained", sb.size(), 0);

        // Good frame right after a timeout is accepted.
        push_cmd(8'h01, 8'h10, 16'h1234);
        send_bytes('{8'hA5, 8'h01, 8'h10, 8'h12, 8'h34, 8'h37}, 1'b1);
        #1;
        check("post_tmo_frame", sb.size(), 0);

        // Byte arriving in the expiry cycle wins over the timeout.
        push_cmd(8'h03, 8'h10, 16'h1234);
        send_bytes('{8'hA5, 8'h03}, 1'b1);
        repeat (TMO - 3) @(negedge clk);
        send_bytes('{8'h10, 8'h12, 8'h34, 8'h35}, 1'b1);
        #1;
        check("expiry_byte_wins", sb.size(), 0);
        check("expiry_cmd", cmd, 8'h03);

        // Back-to-back frames with no idle cycle at all.
        push_cmd(8'h01, 8'h10, 16'h1234);
        push_cmd(8'h02, 8'h20, 16'hABCD);
        send_bytes('{8'hA5, 8'h01, 8'h10, 8'h12, 8'h34, 8'h37,
                     8'hA5, 8'h02, 8'h20, 8'hAB, 8'hCD, 8'h44}, 1'b0);
        #1;
        check("b2b_both_seen", sb.size(), 0);
        check("b2b_cmd", cmd, 8'h02);
        check("b2b_addr", addr, 8'h20);
        check("b2b_wdata", wdata, 16'hABCD);

        // Reset mid-frame: everything clears, no error pulse, next frame decodes.
        @(negedge clk);
        send_bytes('{8'hA5, 8'h01, 8'h10}, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_cmd", cmd, 0);
        check("midrst_addr", addr, 0);
        check("midrst_wdata", wdata, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err_count", err_count, 0);
        check("midrst_pulses", {cmd_valid, csum_err, tmo_err}, 0);
        rst_n   = 1'b1;
        m_cmd   = 8'h00;
        m_addr  = 8'h00;
        m_wdata = 16'h0000;
        m_errc  = 8'h00;
        push_cmd(8'h01, 8'h10, 16'h1234);
        send_bytes('{8'hA5, 8'h01, 8'h10, 8'h12, 8'h34, 8'h37}, 1'b1);
        #1;
        check("post_rst_frame", sb.size(), 0);

        repeat (TMO + 5) @(negedge clk);
        check("final_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
